uriscv_fetch: RTL

Instruction fetch unit for the uRISC-V core: owns the program counter, issues single-outstanding word reads on the instruction memory port, and presents one fetched instruction at a time to decode/execute. It is the receiving end of the branch-resolution outputs (`branch`/`branch_target`): a redirect pulse from execute retargets the PC, squashes any buffered or in-flight instruction, and raises a fetch fault on a misaligned target.

---
 rtl/uriscv_fetch.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uriscv_fetch.sv
// rtl/uriscv_fetch.sv - uRISC-V instruction fetch unit with single-outstanding reads and redirect handling
module uriscv_fetch #(
  parameter logic [31:0] BOOT_VECTOR = 32'h00000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_i_rd_o,
  output logic [31:0] mem_i_pc_o,
  input  logic        mem_i_accept_i,
  input  logic        mem_i_valid_i,
  input  logic [31:0] mem_i_inst_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_pc_o,
  output logic [31:0] fetch_instr_o,
  output logic        fetch_fault_o,
  input  logic        fetch_accept_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_drop;
  logic        r_mem_rd;
  logic [31:0] r_mem_pc;
  logic        r_valid;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;
  logic        r_fault;

  logic        w_redirect;
  logic        w_issue;
  logic [31:0] w_issue_pc;
  logic        w_issue_misaligned;

  // Redirects are honoured everywhere except the single post-reset IDLE cycle
  assign w_redirect         = branch_i && (r_state != S_IDLE);
  assign w_issue_pc         = w_redirect ? branch_target_i : r_pc;
  assign w_issue_misaligned = |w_issue_pc[1:0];

  // Decide whether this cycle ends in a new fetch issue (or a fault entry)
  always_comb begin
    w_issue = 1'b0;
    case (r_state)
      S_IDLE:  w_issue = 1'b1;
      S_REQ:   w_issue = 1'b0;
      S_WAIT:  w_issue = mem_i_valid_i && (r_drop || w_redirect);
      S_HOLD:  w_issue = w_redirect || fetch_accept_i;
      S_FAULT: w_issue = w_redirect;
      S_HALT:  w_issue = w_redirect;
      default: w_issue = 1'b0;
    endcase
  end

  // Fetch FSM: owns the PC, request port, drop flag and output buffer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_pc        <= BOOT_VECTOR;
      r_req_pc    <= 32'h0;
      r_drop      <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_pc    <= 32'h0;
      r_valid     <= 1'b0;
      r_out_pc    <= 32'h0;
      r_out_instr <= 32'h0;
      r_fault     <= 1'b0;
    end else if (w_issue) begin
      r_pc   <= w_issue_pc;
      r_drop <= 1'b0;
      if (w_issue_misaligned) begin
        // Misaligned target never reaches memory; it is presented as a fault entry
        r_state     <= S_FAULT;
        r_mem_rd    <= 1'b0;
        r_valid     <= 1'b1;
        r_out_pc    <= w_issue_pc;
        r_out_instr <= 32'h0;
        r_fault     <= 1'b1;
      end else begin
        r_state  <= S_REQ;
        r_mem_rd <= 1'b1;
        r_mem_pc <= w_issue_pc;
        r_req_pc <= w_issue_pc;
        r_valid  <= 1'b0;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          // Address stays put until accepted; a redirect only marks the response stale
          if (mem_i_accept_i) begin
            r_state  <= S_WAIT;
            r_mem_rd <= 1'b0;
          end
          if (w_redirect) begin
            r_drop <= 1'b1;
            r_pc   <= branch_target_i;
          end
        end
        S_WAIT: begin
          if (mem_i_valid_i) begin
            r_state     <= S_HOLD;
            r_valid     <= 1'b1;
            r_out_pc    <= r_req_pc;
            r_out_instr <= mem_i_inst_i;
            r_fault     <= 1'b0;
            r_pc        <= r_pc + 32'd4;
          end else if (w_redirect) begin
            r_drop <= 1'b1;
            r_pc   <= branch_target_i;
          end
        end
        S_FAULT: begin
          if (fetch_accept_i) begin
            r_state <= S_HALT;
            r_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_i_rd_o    = r_mem_rd;
  assign mem_i_pc_o    = r_mem_pc;
  assign fetch_valid_o = r_valid;
  assign fetch_pc_o    = r_out_pc;
  assign fetch_instr_o = r_out_instr;
  assign fetch_fault_o = r_fault;

endmodule
